// File: rtl/seq_nonrestoring_div.sv
// Sequential non-restoring unsigned divider.
// One quotient bit is produced per clock, followed by a single remainder
// correction step. Operands arrive and results leave through valid/ready
// handshakes, with at most one division in flight at a time.
module seq_nonrestoring_div #(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] q,
    output logic [M-1:0] r,
    output logic         dz
);

    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [M-1:0]  a_q, a_d;      // dividend shifting out, quotient shifting in
    logic [M-1:0]  d_q, d_d;      // divisor
    logic [M:0]    p_q, p_d;      // signed partial remainder
    logic [CW-1:0] cnt_q, cnt_d;  // steps still to perform
    logic [M-1:0]  q_q, q_d;
    logic [M-1:0]  r_q, r_d;
    logic          dz_q, dz_d;

    logic [M:0]    d_ext;
    logic [M:0]    p_shift;
    logic [M:0]    p_step;
    logic [M:0]    p_fix;

    // The divisor is zero-extended into the M+1 bit signed domain; the shift
    // drops the old top bit of P, which is harmless because the arithmetic is
    // modulo 2^(M+1) and every post-step remainder lies within [-D, D).
    assign d_ext   = {1'b0, d_q};
    assign p_shift = {p_q[M-1:0], a_q[M-1]};
    assign p_step  = p_q[M] ? (p_shift + d_ext) : (p_shift - d_ext);
    assign p_fix   = p_q[M] ? (p_q + d_ext) : p_q;

    // Next-state and datapath update for the four-state control FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = x;
                    d_d = y;
                    if (y == '0) begin
                        q_d     = '1;
                        r_d     = x;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        p_d     = '0;
                        cnt_d   = CW'(M);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                p_d   = p_step;
                a_d   = {a_q[M-2:0], ~p_step[M]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                p_d     = p_fix;
                q_d     = a_q;
                r_d     = p_fix[M-1:0];
                dz_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            d_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_seq_nonrestoring_div.sv
// Self-checking bench for seq_nonrestoring_div: directed corner cases,
// output hold under back-pressure, mid-operation reset, then random traffic
// checked against a divide/modulo reference through a result scoreboard.
module tb_seq_nonrestoring_div;

    localparam int M = 32;

    typedef struct packed {
        logic [M-1:0] q;
        logic [M-1:0] r;
        logic         dz;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] x;
    logic [M-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] q;
    logic [M-1:0] r;
    logic         dz;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_nonrestoring_div #(.M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    function automatic res_t model(input logic [M-1:0] xv, input logic [M-1:0] yv);
        res_t e;
        if (yv == '0) begin
            e.q  = '1;
            e.r  = xv;
            e.dz = 1'b1;
        end else begin
            e.q  = xv / yv;
            e.r  = xv % yv;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally stall the consumer, and check result,
    // latency, hold behaviour and return to IDLE.
    task automatic run_op(input logic [M-1:0] xv, input logic [M-1:0] yv,
                          input int stall, input bit chk_lat);
        int   cyc;
        res_t e;
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        x         = xv;
        y         = yv;
        out_ready = (stall == 0);
        sb.push_back(model(xv, yv));
        @(negedge clk);
        in_valid = 1'b0;
        x        = $urandom;
        y        = $urandom;
        cyc      = 1;
        while (!out_valid && cyc < M + 10) begin
            in_valid = 1'($urandom_range(0, 1));
            x        = $urandom;
            y        = $urandom;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("out_valid_seen", out_valid, 1);
        if (!out_valid) begin
            out_ready = 1'b1;
            return;
        end
        if (chk_lat) check("latency", 64'(cyc), (yv == '0) ? 64'd1 : 64'(M + 2));
        check("sb_depth", 64'(sb.size()), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check("q", q, e.q);
        check("r", r, e.r);
        check("dz", dz, e.dz);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            x        = $urandom;
            y        = $urandom;
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_q", q, e.q);
            check("hold_r", r, e.r);
            check("hold_dz", dz, e.dz);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [M-1:0] xr, yr;
        int           mode;
        int           stall;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dz", dz, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases
        run_op(32'd100, 32'd7, 0, 1'b1);
        run_op(32'd5, 32'd9, 0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        run_op(32'd123, 32'd0, 0, 1'b1);

        // Back-pressure: hold DONE for 10 cycles with inputs toggling
        run_op(32'd200, 32'd9, 10, 1'b1);

        // Reset in the middle of RUN aborts the operation
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 32'd1000;
        y         = 32'd3;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midrun_busy", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        check("abort_dz", dz, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < M + 4; i++) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 0);
        end
        run_op(32'd1000, 32'd3, 0, 1'b1);

        // Random traffic with occasional consumer stalls
        for (int n = 0; n < 1200; n++) begin
            mode = $urandom_range(0, 5);
            xr   = $urandom;
            case (mode)
                0: yr = 32'd1;
                1: begin
                    xr = $urandom_range(0, 1000000);
                    yr = xr + 32'd1 + 32'($urandom_range(0, 1000));
                end
                2: yr = 32'($urandom_range(0, 255));
                3: yr = $urandom >> $urandom_range(0, 31);
                4: yr = (n % 50 == 0) ? 32'd0 : $urandom;
                default: yr = $urandom;
            endcase
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_op(xr, yr, stall, 1'b1);
        end

        check("sb_final_empty", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
